// File: rtl/right_shift_serializer_pkg.sv
// ============================================================================
// Module      : right_shift_serializer_pkg
// Description : Shared types for the LSB-first serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package right_shift_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/right_shift_serializer_counter.sv
// ============================================================================
// Module      : bit_down_counter
// Description : Loadable down counter with zero/one flags; load beats decrement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             one
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);
  assign one   = (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/right_shift_serializer.sv
// ============================================================================
// Module      : right_shift_serializer
// Description : Parallel-in, LSB-first serial-out transmitter with handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module right_shift_serializer
  import right_shift_serializer_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] load_data,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            enable,
  output logic            out,
  output logic            out_valid,
  output logic            last
);

  localparam int              CNT_W  = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0] C_SIZE = CNT_W'(SIZE);

  logic [SIZE-1:0]  r_shreg;
  logic [CNT_W-1:0] w_count;
  logic             w_zero;
  logic             w_one;
  logic             w_accept;
  logic             w_shift;
  state_t           w_state;

  // A load on the last-bit edge overrides the final shift, so words abut.
  assign w_accept = load_valid && load_ready;
  assign w_shift  = out_valid && !w_accept;

  bit_down_counter #(
    .WIDTH (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_accept),
    .load_value (C_SIZE),
    .dec        (w_shift),
    .count      (w_count),
    .zero       (w_zero),
    .one        (w_one)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= load_data;
    end else if (w_shift) begin
      r_shreg <= {1'b0, r_shreg[SIZE-1:1]};
    end
  end

  always_comb begin
    w_state    = w_zero ? ST_IDLE : ST_SHIFT;
    out_valid  = 1'b0;
    last       = 1'b0;
    load_ready = 1'b0;
    case (w_state)
      ST_IDLE: begin
        load_ready = !reset;
      end
      ST_SHIFT: begin
        out_valid  = enable;
        last       = enable && w_one;
        load_ready = !reset && enable && w_one;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  assign out = r_shreg[0];

endmodule

`default_nettype wire

// File: tb/tb_right_shift_serializer.sv
// ============================================================================
// Module      : tb_right_shift_serializer
// Description : Directed bench with a behavioural right-shift receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_right_shift_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       enable;
  logic       out;
  logic       out_valid;
  logic       last;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx;

  right_shift_serializer #(
    .SIZE (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .enable     (enable),
    .out        (out),
    .out_valid  (out_valid),
    .last       (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver: right-shift deserializer, new bit enters at the MSB.
  always @(posedge clk) begin
    if (out_valid) rx <= {out, rx[7:1]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input string tag);
    load_data  = w;
    load_valid = 1'b1;
    enable     = 1'b1;
    check({tag, "_ready"}, 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    load_data  = ~w;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_out"},   32'(out),        32'(w[k]));
      check({tag, "_valid"}, 32'(out_valid),  32'd1);
      check({tag, "_last"},  32'(last),       32'(k == 7));
      check({tag, "_rdy"},   32'(load_ready), 32'(k == 7));
      step();
    end
    check({tag, "_rx"},        32'(rx),        32'(w));
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] seq;
    logic [7:0]  w;

    reset      = 1'b1;
    load_data  = 8'h00;
    load_valid = 1'b0;
    enable     = 1'b0;

    // Reset then idle
    step();
    check("rst_ready",  32'(load_ready), 32'd0);
    check("rst_out",    32'(out),        32'd0);
    check("rst_valid",  32'(out_valid),  32'd0);
    check("rst_last",   32'(last),       32'd0);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    check("rst_ignore", 32'(dut.w_count), 32'd0);
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("idle_ready", 32'(load_ready), 32'd1);
    enable = 1'b1;
    #1;
    check("idle_en_valid", 32'(out_valid), 32'd0);
    step();

    // Single word
    send_word(8'hA5, "a5");

    // Back-to-back: 3C then FF held until accepted on 3C's last-bit edge
    seq = 16'hFF3C;
    load_data  = 8'h3C;
    load_valid = 1'b1;
    enable     = 1'b1;
    step();
    load_data = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      check("b2b_out",   32'(out),        32'(seq[i]));
      check("b2b_valid", 32'(out_valid),  32'd1);
      check("b2b_last",  32'(last),       32'(i == 7 || i == 15));
      check("b2b_rdy",   32'(load_ready), 32'(i == 7 || i == 15));
      step();
      if (i == 7) load_valid = 1'b0;
    end
    check("b2b_rx",   32'(rx),        32'hFF);
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Stall for 3 cycles with bit 3 pending
    w = 8'h81;
    load_data  = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_pre_out", 32'(out), 32'(w[k]));
      step();
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_valid", 32'(out_valid),     32'd0);
      check("stall_last",  32'(last),          32'd0);
      check("stall_rdy",   32'(load_ready),    32'd0);
      check("stall_cnt",   32'(dut.w_count),   32'd5);
      check("stall_out",   32'(out),           32'(w[3]));
      step();
    end
    enable = 1'b1;
    #1;
    for (int k = 3; k < 8; k++) begin
      check("stall_post_out",   32'(out),       32'(w[k]));
      check("stall_post_valid", 32'(out_valid), 32'd1);
      check("stall_post_last",  32'(last),      32'(k == 7));
      step();
    end
    check("stall_rx", 32'(rx), 32'(w));

    // Loopback into receiver
    send_word(8'h5A, "5a");

    // Reset mid-word
    w = 8'hF0;
    load_data  = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("mid_out", 32'(out), 32'(w[k]));
      step();
    end
    reset = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out",   32'(out),       32'd0);
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rel_ready", 32'(load_ready), 32'd1);
    send_word(8'h0F, "0f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/right_shift_serializer.md
# right_shift_serializer

Parallel-in, serial-out transmitter, the sending end of the LSB-first serial link that our right-shift deserializer receives. It accepts a SIZE-bit word over a valid/ready handshake and emits it one bit per enabled cycle, bit 0 first. `out`/`out_valid` connect directly to the receiver's `in`/`enable`. After SIZE enabled cycles the receiver's parallel output equals the transmitted word.

## Interface
- SIZE, 8, word width in bits; legal range SIZE >= 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- load_data  input  SIZE  parallel word to transmit.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block accepts a word this cycle; a word transfers when load_valid && load_ready at the clock edge.
- enable  input  1  link advance permission; when low, transmission stalls.
- out  output  1  serial data bit, equal to shreg[0].
- out_valid  output  1  out carries a real bit this cycle; drives receiver enable.
- last  output  1  high during the cycle that presents the final bit (bit SIZE-1) of a word.

## Operation
- State: shreg[SIZE-1:0], cnt (width $clog2(SIZE+1)) holding the number of bits remaining, and busy = (cnt != 0).
- States:
  - IDLE (cnt==0): out_valid=0; load_ready=1.
  - SHIFT (cnt>0): out_valid = enable.
- Accept: on load_valid && load_ready, set shreg <= load_data and cnt <= SIZE.
- Shift: on an edge with out_valid=1 and no accept, set shreg <= {1'b0, shreg[SIZE-1:1]} and cnt <= cnt-1.
- last = out_valid && (cnt==1).
- load_ready = !busy || last. This allows a back-to-back load on the last-bit edge: the new word's load wins over the shift, so there is no idle gap between words.
- enable low in SHIFT:
  - out_valid=0; shreg and cnt hold.
  - out still shows shreg[0], but the receiver ignores it.
  - load_ready=0 unless cnt==0.
- enable in IDLE: no effect.
- load_valid while busy and not last: ignored; the word is not captured and the sender must hold it until ready.
- load_data changes while load_valid is low: no effect.

## Timing
- Reset (edge with reset=1): shreg=0 and cnt=0. After that edge, out=0, out_valid=0, last=0, load_ready=1.
  - While reset is high, load_ready is forced to 0 and load_valid is ignored.
- Reset mid-word: the word is abandoned, with no further out_valid. The receiver sees a truncated word; the link owner must reset both ends together.
- Latency: word accepted at edge T → bit 0 on out, with out_valid=enable, in cycle T+1.
  - With enable held high, bit k appears in cycle T+1+k, and last is asserted in cycle T+SIZE.
- Throughput: one word per SIZE enabled cycles, sustained, with no bubbles.
- out, out_valid, last and load_ready are combinational from registers plus enable/load_valid. No combinational path runs from load_data to any output.

## Structure
- No shared package is needed; localparam CNT_W = $clog2(SIZE+1) lives in the module.
- One natural sub-module: `bit_down_counter` (parameter WIDTH).
  - Inputs: load, load value, decrement.
  - Outputs: count, zero, one flags.
  - Load takes priority over decrement.
- The shift register datapath stays in the top module.
- Expected RTL is about 150 lines, including the counter.

## Test plan
- Reset then idle:
  - Stimulus: reset high for 2 cycles, then low.
  - Required: out=0, out_valid=0, last=0, and load_ready=1 only after reset is released.
- Single word (SIZE=8):
  - Stimulus: load 8'hA5 with enable=1.
  - Required: out sequence 1,0,1,0,0,1,0,1 over cycles T+1..T+8; last only at T+8; load_ready=0 during T+1..T+7.
- Back-to-back:
  - Stimulus: load 8'h3C, then 8'hFF presented continuously.
  - Required: 8'hFF is accepted on the last-bit edge of 8'h3C; 16 consecutive out_valid cycles with no gap.
- Stall:
  - Stimulus: word 8'h81; drop enable for 3 cycles after bit 2.
  - Required: out_valid=0 and cnt holds during the stall; the remaining bits resume in order; last is delayed by 3 cycles.
- Loopback with receiver:
  - Stimulus: connect out→in and out_valid→enable on the deserializer; send 8'h5A.
  - Required: the receiver's out equals 8'h5A on the cycle after last.
- Reset mid-word:
  - Stimulus: assert reset after bit 4 of 8'hF0.
  - Required: out_valid=0 immediately after the reset edge; a subsequent load of 8'h0F transmits correctly.
